a_ref_cal: RTL and testbench
============================

A_REF_CAL -- requirements
Module: a_ref_cal

Interface
REQ-001 Parameter DLY_W, default 9: width of the delay-select code driven to the ring delay cells.
REQ-002 Parameter CNT_W, default 12: width of the oscillator edge counter and of the target.
REQ-003 Parameter WIN_CYC, default 256: measurement window length, in i_clk cycles.
REQ-004 Parameter SETTLE_CYC, default 16: i_clk cycles waited after each code change.
REQ-005 Parameter TOL, default 2: lock tolerance, in counts.
REQ-006 Port i_clk, input, 1: single system clock; all state on its rising edge.
REQ-007 Port i_rstn, input, 1: reset, asynchronous and active-low.
REQ-008 Port i_start, input, 1: calibration request; sampled only in IDLE or DONE.
REQ-009 Port i_target, input, CNT_W: wanted rising-edge count per window; sampled at start.
REQ-010 Port i_osc, input, 1: ring oscillator output, asynchronous to i_clk.
REQ-011 Port o_dly_sel, output, DLY_W: delay-select code to the ring.
REQ-012 Port o_mode, output, 1: ring mux select; 1 = ring closed, 0 = test clock.
REQ-013 Port o_busy, output, 1: high in every state except IDLE and DONE.
REQ-014 Port o_done, output, 1: high in DONE.
REQ-015 Port o_lock, output, 1: final |count - target| <= TOL; valid while o_done is high.
REQ-016 Port o_count, output, CNT_W: count from the last completed window.

Function
REQ-017 The FSM SHALL have the states IDLE, SETTLE, MEASURE, COMPARE, FINAL and DONE.
REQ-018 On i_start in IDLE or DONE, the block SHALL:
- latch i_target;
- set o_dly_sel to 1 followed by DLY_W-1 zeros (MSB trial);
- set the bit index to DLY_W-1 and o_mode=1;
- enter SETTLE on the next cycle.
REQ-019 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter MEASURE with the edge counter cleared.
REQ-020 MEASURE SHALL last exactly WIN_CYC cycles, counting each synchronised rising edge of i_osc.
REQ-021 The edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 COMPARE SHALL last 1 cycle and SHALL:
- update o_count;
- if count > target (ring too fast), keep the trial bit, else clear it;
- if bit index > 0, set the next lower bit as the new trial and return to SETTLE;
- at bit 0, go to SETTLE with no trial bit and flag the FINAL pass.
REQ-023 FINAL is the last SETTLE+MEASURE at the resolved code. It SHALL update o_count, set o_lock per REQ-015, and enter DONE.
REQ-024 In DONE the block SHALL hold o_dly_sel, o_mode=1 and o_lock until the next i_start.
REQ-025 Start-to-done latency SHALL be exactly 1 + (DLY_W+1)*(SETTLE_CYC+WIN_CYC+1) cycles, i.e. 2731 cycles with the default parameters.
REQ-026 i_start while o_busy=1 SHALL be ignored.
REQ-027 A change of i_target during a run SHALL have no effect.
REQ-028 i_start in DONE SHALL restart a full search from the MSB trial.
REQ-029 Equality SHALL be handled as follows:
- count == target clears the trial bit (shorter delay is preferred);
- an all-zero resolved code is legal.
REQ-030 Comparison SHALL be unsigned; |count - target| SHALL be computed in CNT_W+1 bits.

Reset
REQ-031 While i_rstn=0, the outputs SHALL be:
- FSM = IDLE;
- o_dly_sel = 0;
- o_mode = 0;
- o_busy, o_done and o_lock = 0;
- o_count = 0;
- counters and synchroniser = 0.
REQ-032 Reset asserted mid-run SHALL abort immediately to the REQ-031 values.
REQ-033 After reset, a new run SHALL need a fresh i_start.

Structure
REQ-034 Package a_ref_pkg SHALL hold:
- the FSM state type;
- the default parameter constants;
- the derived counter widths.
REQ-035 Sub-module a_osc_edge SHALL provide:
- a 2-flop synchroniser on i_osc plus a third flop for edge detection;
- a 1-cycle rising-edge pulse output;
- reset to 0.
REQ-036 Window and settle counters SHALL be sized by clog2 of their cycle counts.

Verification
REQ-037 The bench SHALL use a ring model with period = 3 + o_dly_sel/8 i_clk cycles, target 40, and default parameters. Required response: o_done 2731 cycles after start, o_lock=1, o_count within 38..42.
REQ-038 Target 4095, with i_osc tied low: all counts are 0, so o_dly_sel resolves to 0, o_count=0 and o_lock=0.
REQ-039 Target 0, with a ring faster than all codes: every bit is kept, so o_dly_sel=9'h1FF.
REQ-040 i_start pulsed repeatedly mid-run: the run is unaffected and the latency remains 2731 cycles.
REQ-041 i_rstn low during MEASURE of bit 5: all outputs reach their reset values without waiting for i_clk, and the next run from i_start matches the REQ-037 result.
REQ-042 With CNT_W=4 and a fast ring: o_count saturates at 15 and does not wrap.

Source files
------------

// File: rtl/a_ref_pkg.sv
// Shared types and default sizing for the ring-oscillator delay calibrator.
// Holds the search FSM state encoding and the counter widths derived from the default parameters.
package a_ref_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_FINAL   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DLY_W_DEF      = 9;
  localparam int CNT_W_DEF      = 12;
  localparam int WIN_CYC_DEF    = 256;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int TOL_DEF        = 2;

  localparam int WIN_W_DEF    = $clog2(WIN_CYC_DEF);
  localparam int SETTLE_W_DEF = $clog2(SETTLE_CYC_DEF);

endpackage

// File: rtl/a_osc_edge.sv
// Brings the asynchronous ring output into the i_clk domain and flags each rising edge.
// Produces a one-cycle pulse per rising edge of the ring output.
module a_osc_edge (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_osc,
  output logic o_rise
);

  // sync_r[1:0] is the two-flop synchroniser, sync_r[2] holds the previous synchronised level
  logic [2:0] sync_r;

  // Synchroniser and edge-history shift register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], i_osc};
    end
  end

  assign o_rise = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/a_ref_cal.sv
// Successive-approximation calibration of a ring-oscillator delay code.
// Each bit trial settles the ring, counts its edges over a fixed window and keeps the bit if the ring runs too fast.
module a_ref_cal
  import a_ref_pkg::*;
#(
  parameter int DLY_W      = DLY_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_CYC    = WIN_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TOL        = TOL_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_target,
  input  logic             i_osc,
  output logic [DLY_W-1:0] o_dly_sel,
  output logic             o_mode,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_lock,
  output logic [CNT_W-1:0] o_count
);

  localparam int BIT_W    = (DLY_W > 1) ? $clog2(DLY_W) : 1;
  localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1'b1);
  localparam logic [CNT_W:0]      TOL_V       = (CNT_W + 1)'(TOL);
  localparam logic [DLY_W-1:0]    DLY_ONE     = DLY_W'(1'b1);
  localparam logic [DLY_W-1:0]    DLY_MSB     = DLY_ONE << (DLY_W - 1);
  localparam logic [BIT_W-1:0]    BIT_TOP     = BIT_W'(DLY_W - 1);
  localparam logic [BIT_W-1:0]    BIT_ONE     = BIT_W'(1'b1);

  state_t               state_r, state_s;
  logic [BIT_W-1:0]     bit_r;
  logic                 final_r;
  logic [CNT_W-1:0]     target_r;
  logic [SETTLE_W-1:0]  settle_cnt_r;
  logic [WIN_W-1:0]     win_cnt_r;
  logic [CNT_W-1:0]     edge_cnt_r;
  logic [DLY_W-1:0]     dly_sel_r;
  logic                 mode_r, busy_r, done_r, lock_r;
  logic [CNT_W-1:0]     count_r;

  logic                 rise_s, settle_end_s, win_end_s, keep_s, lock_s;
  logic [CNT_W:0]       cnt_x_s, tgt_x_s, diff_s;
  logic [BIT_W-1:0]     bit_dn_s;
  logic [DLY_W-1:0]     cur_mask_s, low_mask_s, dly_trial_s;

  a_osc_edge u_osc_edge (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_osc  (i_osc),
    .o_rise (rise_s)
  );

  assign settle_end_s = (settle_cnt_r == SETTLE_LAST);
  assign win_end_s    = (win_cnt_r == WIN_LAST);

  // A ring that is too fast needs more delay, so the trial bit survives; a tie prefers the shorter delay
  assign keep_s  = (edge_cnt_r > target_r);
  assign cnt_x_s = {1'b0, edge_cnt_r};
  assign tgt_x_s = {1'b0, target_r};
  assign diff_s  = (cnt_x_s >= tgt_x_s) ? (cnt_x_s - tgt_x_s) : (tgt_x_s - cnt_x_s);
  assign lock_s  = (diff_s <= TOL_V);

  assign bit_dn_s    = bit_r - BIT_ONE;
  assign cur_mask_s  = DLY_ONE << bit_r;
  assign low_mask_s  = (bit_r != {BIT_W{1'b0}}) ? (DLY_ONE << bit_dn_s) : {DLY_W{1'b0}};
  assign dly_trial_s = (keep_s ? dly_sel_r : (dly_sel_r & ~cur_mask_s)) | low_mask_s;

  // Search FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Search FSM next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_start) state_s = ST_SETTLE;
        else         state_s = state_r;
      end
      ST_SETTLE: begin
        if (settle_end_s) state_s = ST_MEASURE;
        else              state_s = ST_SETTLE;
      end
      ST_MEASURE: begin
        if (win_end_s) state_s = final_r ? ST_FINAL : ST_COMPARE;
        else           state_s = ST_MEASURE;
      end
      ST_COMPARE: state_s = ST_SETTLE;
      ST_FINAL:   state_s = ST_DONE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Trial code, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bit_r        <= {BIT_W{1'b0}};
      final_r      <= 1'b0;
      target_r     <= {CNT_W{1'b0}};
      settle_cnt_r <= {SETTLE_W{1'b0}};
      win_cnt_r    <= {WIN_W{1'b0}};
      edge_cnt_r   <= {CNT_W{1'b0}};
      dly_sel_r    <= {DLY_W{1'b0}};
      mode_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      lock_r       <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            target_r     <= i_target;
            dly_sel_r    <= DLY_MSB;
            bit_r        <= BIT_TOP;
            mode_r       <= 1'b1;
            final_r      <= 1'b0;
            lock_r       <= 1'b0;
            settle_cnt_r <= {SETTLE_W{1'b0}};
          end else begin
            dly_sel_r <= dly_sel_r;
          end
        end
        ST_SETTLE: begin
          settle_cnt_r <= settle_end_s ? {SETTLE_W{1'b0}} : (settle_cnt_r + SETTLE_W'(1'b1));
          win_cnt_r    <= {WIN_W{1'b0}};
          edge_cnt_r   <= {CNT_W{1'b0}};
        end
        ST_MEASURE: begin
          win_cnt_r <= win_cnt_r + WIN_W'(1'b1);
          if (rise_s && (edge_cnt_r != CNT_MAX)) edge_cnt_r <= edge_cnt_r + CNT_ONE;
          else                                   edge_cnt_r <= edge_cnt_r;
        end
        ST_COMPARE: begin
          count_r      <= edge_cnt_r;
          dly_sel_r    <= dly_trial_s;
          settle_cnt_r <= {SETTLE_W{1'b0}};
          if (bit_r != {BIT_W{1'b0}}) begin
            bit_r <= bit_dn_s;
          end else begin
            final_r <= 1'b1;
          end
        end
        ST_FINAL: begin
          count_r <= edge_cnt_r;
          lock_r  <= lock_s;
        end
        default: begin
          final_r <= 1'b0;
        end
      endcase
      busy_r <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign o_dly_sel = dly_sel_r;
  assign o_mode    = mode_r;
  assign o_busy    = busy_r;
  assign o_done    = done_r;
  assign o_lock    = lock_r;
  assign o_count   = count_r;

endmodule

// File: tb/tb_a_ref_cal.sv
// Directed bench for a_ref_cal: default-parameter searches against a ring model, plus a narrow
// counter instance to check saturation.
module tb_a_ref_cal;

  logic        clk, rst_n;
  logic        start;
  logic [11:0] target;
  logic        osc;
  logic [8:0]  dly_sel;
  logic        mode, busy, done, lock;
  logic [11:0] count;

  logic        start2;
  logic [3:0]  target2;
  logic        osc2;
  logic [2:0]  dly2;
  logic        mode2, busy2, done2, lock2;
  logic [3:0]  count2;

  int vectors    = 0;
  int miscompares = 0;
  int osc_mode   = 0;  // 0 = tied low, 1 = ring model from dly_sel, 2 = fixed fast ring

  a_ref_cal dut (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_target(target), .i_osc(osc),
    .o_dly_sel(dly_sel), .o_mode(mode), .o_busy(busy), .o_done(done), .o_lock(lock),
    .o_count(count)
  );

  a_ref_cal #(.DLY_W(3), .CNT_W(4), .WIN_CYC(64), .SETTLE_CYC(4), .TOL(2)) dut_sat (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start2), .i_target(target2), .i_osc(osc2),
    .o_dly_sel(dly2), .o_mode(mode2), .o_busy(busy2), .o_done(done2), .o_lock(lock2),
    .o_count(count2)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial osc2 = 1'b0;
  always #150 osc2 = ~osc2;

  // Ring period = (3 + dly_sel/8) clock periods of 100 units
  initial osc = 1'b0;
  always begin
    if (osc_mode == 0) begin
      osc = 1'b0;
      #50;
    end else if (osc_mode == 1) begin
      osc = ~osc;
      #(150 + (int'(dly_sel) * 25) / 4);
    end else begin
      osc = ~osc;
      #150;
    end
  end

  task automatic set_osc(input int m);
    osc_mode = m;
    repeat (50) @(posedge clk);
  endtask

  task automatic pulse_start(input logic [11:0] tgt);
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit poke, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 4000) begin
      @(posedge clk);
      #1;
      lat = lat + 1;
      if (poke) begin
        start = (lat % 97 == 0);
        if (lat == 600) target = 12'hFFF;
      end
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: o_done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic check_locked_run(input string tag, input int lat);
    vectors++;
    if (lat !== 2731) begin miscompares++; $display("FAIL %s_latency: got %0d, required 2731", tag, lat); end
    vectors++;
    if (lock !== 1'b1) begin miscompares++; $display("FAIL %s_lock: got %b, required 1", tag, lock); end
    vectors++;
    if (count < 12'd38 || count > 12'd42) begin
      miscompares++; $display("FAIL %s_count: got %0d, required 38..42", tag, count);
    end
    vectors++;
    if (busy !== 1'b0 || mode !== 1'b1) begin
      miscompares++; $display("FAIL %s_flags: busy=%b mode=%b, required busy=0 mode=1", tag, busy, mode);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; target = 12'd0; start2 = 1'b0; target2 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (dly_sel !== 9'd0 || count !== 12'd0) begin
      miscompares++; $display("FAIL reset_data: dly_sel=%h count=%0d, required 0/0", dly_sel, count);
    end
    vectors++;
    if (mode !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || lock !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: mode=%b busy=%b done=%b lock=%b, required all 0", mode, busy, done, lock);
    end
    vectors++;
    if (count2 !== 4'd0 || busy2 !== 1'b0) begin
      miscompares++; $display("FAIL reset_sat: count2=%0d busy2=%b, required 0/0", count2, busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    int lat;
    set_osc(1);
    pulse_start(12'd40);
    wait_done(1'b0, lat);
    check_locked_run("lock", lat);
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || mode !== 1'b1 || lock !== 1'b1) begin
      miscompares++; $display("FAIL done_hold: done=%b mode=%b lock=%b, required 1/1/1", done, mode, lock);
    end
  endtask

  task automatic test_restart_from_done;
    int lat;
    pulse_start(12'd40);
    vectors++;
    if (dly_sel !== 9'h100) begin miscompares++; $display("FAIL restart_msb: got %h, required 100", dly_sel); end
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || mode !== 1'b1) begin
      miscompares++; $display("FAIL restart_flags: busy=%b done=%b mode=%b, required 1/0/1", busy, done, mode);
    end
    wait_done(1'b0, lat);
    check_locked_run("restart", lat);
  endtask

  task automatic test_busy_ignore;
    int lat;
    pulse_start(12'd40);
    wait_done(1'b1, lat);
    check_locked_run("busy_ignore", lat);
  endtask

  task automatic test_osc_low;
    int lat;
    set_osc(0);
    pulse_start(12'hFFF);
    wait_done(1'b0, lat);
    vectors++;
    if (lat !== 2731) begin miscompares++; $display("FAIL low_latency: got %0d, required 2731", lat); end
    vectors++;
    if (dly_sel !== 9'h000) begin miscompares++; $display("FAIL low_code: got %h, required 000", dly_sel); end
    vectors++;
    if (count !== 12'd0 || lock !== 1'b0) begin
      miscompares++; $display("FAIL low_result: count=%0d lock=%b, required 0/0", count, lock);
    end
  endtask

  task automatic test_fast_all_kept;
    int lat;
    set_osc(2);
    pulse_start(12'd0);
    wait_done(1'b0, lat);
    vectors++;
    if (dly_sel !== 9'h1FF) begin miscompares++; $display("FAIL fast_code: got %h, required 1ff", dly_sel); end
    vectors++;
    if (lock !== 1'b0) begin miscompares++; $display("FAIL fast_lock: got %b, required 0", lock); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    set_osc(1);
    pulse_start(12'd40);
    // Pass for bit 5 begins 3*273 cycles after start; 16 settle cycles later it is measuring
    repeat (3 * 273 + 16 + 100) @(posedge clk);
    #20;
    vectors++;
    if (busy !== 1'b1 || dly_sel !== 9'h020) begin
      miscompares++; $display("FAIL mid_trial: busy=%b dly_sel=%h, required 1/020", busy, dly_sel);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dly_sel !== 9'd0 || count !== 12'd0 || mode !== 1'b0) begin
      miscompares++; $display("FAIL abort_data: dly_sel=%h count=%0d mode=%b, required 0", dly_sel, count, mode);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || lock !== 1'b0) begin
      miscompares++; $display("FAIL abort_flags: busy=%b done=%b lock=%b, required 0", busy, done, lock);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || dly_sel !== 9'd0) begin
      miscompares++; $display("FAIL no_autostart: busy=%b dly_sel=%h, required 0/000", busy, dly_sel);
    end
    pulse_start(12'd40);
    wait_done(1'b0, lat);
    check_locked_run("after_reset", lat);
  endtask

  task automatic test_saturation;
    int lat;
    @(negedge clk);
    target2 = 4'd15;
    start2  = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = 1;
    while (done2 !== 1'b1 && lat < 1000) begin
      @(posedge clk);
      #1;
      lat = lat + 1;
    end
    vectors++;
    if (lat !== 277) begin miscompares++; $display("FAIL sat_latency: got %0d, required 277", lat); end
    vectors++;
    if (count2 !== 4'd15) begin miscompares++; $display("FAIL sat_count: got %0d, required 15", count2); end
    vectors++;
    if (dly2 !== 3'd0 || lock2 !== 1'b1) begin
      miscompares++; $display("FAIL sat_result: dly2=%h lock2=%b, required 0/1", dly2, lock2);
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_restart_from_done;
    test_busy_ignore;
    test_osc_low;
    test_fast_all_kept;
    test_reset_mid_run;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
